// File: rtl/sha256_block_sequencer.sv
// Control sequencer for the SHA-256 compression datapath: IV load, 16-word message fetch,
// 64 rounds and digest accumulation for a job of 1..MAX_BLOCKS blocks.
module sha256_block_sequencer #(
  parameter int unsigned WORDS      = 16,
  parameter int unsigned ROUNDS     = 64,
  parameter int unsigned MAX_BLOCKS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] num_blocks,
  input  logic       abort,
  input  logic       msg_valid,
  output logic       msg_ready,
  output logic [3:0] msg_word_idx,
  output logic       load_iv,
  output logic       abc_load,
  output logic       round_en,
  output logic [5:0] round,
  output logic       h_update,
  output logic [1:0] block_sel,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LastWord  = 4'(WORDS - 1);
  localparam logic [5:0] LastRound = 6'(ROUNDS - 1);
  localparam logic [1:0] MaxBlk    = 2'(MAX_BLOCKS);

  typedef enum logic [2:0] {StIdle, StInit, StLoad, StRound, StUpdate, StDone} state_e;

  state_e     state_q, state_d;
  logic [3:0] word_q, word_d;
  logic [5:0] rnd_q, rnd_d;
  logic [1:0] blk_q, blk_d;
  logic [1:0] nblk_q, nblk_d;
  logic [1:0] sel_q, sel_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      word_q  <= '0;
      rnd_q   <= '0;
      blk_q   <= '0;
      nblk_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      rnd_q   <= rnd_d;
      blk_q   <= blk_d;
      nblk_q  <= nblk_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    rnd_d     = rnd_q;
    blk_d     = blk_q;
    nblk_d    = nblk_q;
    sel_d     = sel_q;
    err_d     = 1'b0;
    msg_ready = 1'b0;
    load_iv   = 1'b0;
    abc_load  = 1'b0;
    round_en  = 1'b0;
    h_update  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          if (num_blocks != 2'd0 && num_blocks <= MaxBlk) begin
            nblk_d  = num_blocks;
            sel_d   = 2'd0;
            state_d = StInit;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StInit: begin
        busy    = 1'b1;
        load_iv = 1'b1;
        blk_d   = 2'd1;
        state_d = StLoad;
      end
      StLoad: begin
        busy      = 1'b1;
        msg_ready = 1'b1;
        if (msg_valid) begin
          if (word_q == LastWord) begin
            word_d   = '0;
            abc_load = 1'b1;
            state_d  = StRound;
          end else begin
            word_d = word_q + 4'd1;
          end
        end
      end
      StRound: begin
        busy     = 1'b1;
        round_en = 1'b1;
        if (rnd_q == LastRound) begin
          rnd_d   = '0;
          // Present the block code to the H registers during the UPDATE cycle itself.
          sel_d   = blk_q;
          state_d = StUpdate;
        end else begin
          rnd_d = rnd_q + 6'd1;
        end
      end
      StUpdate: begin
        busy     = 1'b1;
        h_update = 1'b1;
        if (blk_q < nblk_q) begin
          blk_d   = blk_q + 2'd1;
          state_d = StLoad;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything and suppresses any commit to the digest.
    if (abort && state_q != StIdle) begin
      state_d  = StIdle;
      word_d   = '0;
      rnd_d    = '0;
      blk_d    = '0;
      sel_d    = '0;
      abc_load = 1'b0;
      h_update = 1'b0;
      done     = 1'b0;
    end
  end

  assign msg_word_idx = word_q;
  assign round        = rnd_q;
  assign block_sel    = sel_q;
  assign err          = err_q;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Scoreboard bench: a cycle-level timeline of expected outputs is built from the job
// description (blocks, stall schedule, abort point) and checked by a separate monitor.
module tb_sha256_block_sequencer;

  logic       clk, rst_n, start, abort, msg_valid;
  logic [1:0] num_blocks;
  logic       msg_ready, load_iv, abc_load, round_en, h_update, busy, done, err;
  logic [3:0] msg_word_idx;
  logic [5:0] round;
  logic [1:0] block_sel;

  sha256_block_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_blocks   (num_blocks),
    .abort        (abort),
    .msg_valid    (msg_valid),
    .msg_ready    (msg_ready),
    .msg_word_idx (msg_word_idx),
    .load_iv      (load_iv),
    .abc_load     (abc_load),
    .round_en     (round_en),
    .round        (round),
    .h_update     (h_update),
    .block_sel    (block_sel),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [19:0] exp_q[$];
  logic        mv_q[$];
  logic        ab_q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        fin = 1'b0;
  logic [1:0]  last_sel;

  logic [19:0] dut_vec;
  assign dut_vec = {busy, msg_ready, msg_word_idx, load_iv, abc_load, round_en, round,
                    h_update, block_sel, done, err};

  function automatic logic [19:0] mk(input logic b, input logic rdy, input int ix,
                                     input logic li, input logic al, input logic re,
                                     input int rn, input logic hu, input logic [1:0] s,
                                     input logic dn, input logic er);
    return {b, rdy, 4'(ix), li, al, re, 6'(rn), hu, s, dn, er};
  endfunction

  function automatic logic [19:0] idle_vec(input logic [1:0] s);
    return mk(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, s, 1'b0, 1'b0);
  endfunction

  task automatic push(input logic [19:0] v, input logic mv, input logic ab);
    exp_q.push_back(v);
    mv_q.push_back(mv);
    ab_q.push_back(ab);
  endtask

  // Apply per-cycle msg_valid/abort from the schedule, one entry per clock.
  task automatic drive();
    while (mv_q.size() > 0) begin
      msg_valid = mv_q.pop_front();
      abort     = ab_q.pop_front();
      @(posedge clk);
      #1;
    end
    msg_valid = 1'b0;
    abort     = 1'b0;
  endtask

  // stall_mode: 0 none, 1 random, 2 three stall cycles at word 5 of block 1.
  task automatic build_job(input int nb, input int stall_mode, input int ab_blk,
                           input int ab_rnd);
    logic [1:0] sel = 2'd0;
    int ns;
    push(mk(1, 0, 0, 1, 0, 0, 0, 0, sel, 0, 0), 1'b0, 1'b0);
    for (int b = 1; b <= nb; b++) begin
      for (int w = 0; w < 16; w++) begin
        ns = 0;
        if (stall_mode == 1 && $urandom_range(0, 3) == 0) ns = $urandom_range(1, 2);
        if (stall_mode == 2 && b == 1 && w == 5) ns = 3;
        repeat (ns) push(mk(1, 1, w, 0, 0, 0, 0, 0, sel, 0, 0), 1'b0, 1'b0);
        push(mk(1, 1, w, 0, (w == 15), 0, 0, 0, sel, 0, 0), 1'b1, 1'b0);
      end
      for (int r = 0; r < 64; r++) begin
        if (b == ab_blk && r == ab_rnd) begin
          push(mk(1, 0, 0, 0, 0, 1, r, 0, sel, 0, 0), 1'b0, 1'b1);
          push(idle_vec(2'd0), 1'b0, 1'b0);
          last_sel = 2'd0;
          return;
        end
        push(mk(1, 0, 0, 0, 0, 1, r, 0, sel, 0, 0), 1'b0, 1'b0);
      end
      sel = 2'(b);
      push(mk(1, 0, 0, 0, 0, 0, 0, 1, sel, 0, 0), 1'b0, 1'b0);
    end
    push(mk(1, 0, 0, 0, 0, 0, 0, 0, sel, 1, 0), 1'b0, 1'b0);
    push(idle_vec(sel), 1'b0, 1'b0);
    last_sel = sel;
  endtask

  task automatic run_job(input int nb, input int stall_mode, input int ab_blk, input int ab_rnd);
    start      = 1'b1;
    num_blocks = 2'(nb);
    @(posedge clk);
    #1;
    start = 1'b0;
    build_job(nb, stall_mode, ab_blk, ab_rnd);
    drive();
  endtask

  task automatic bad_start(input logic [1:0] nb);
    start      = 1'b1;
    num_blocks = nb;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(mk(0, 0, 0, 0, 0, 0, 0, 0, last_sel, 0, 1), 1'b0, 1'b0);
    push(idle_vec(last_sel), 1'b0, 1'b0);
    drive();
  endtask

  always @(negedge clk) begin
    logic [19:0] e;
    cyc++;
    if (!rst_n) begin
      checks++;
      if (dut_vec !== 20'h0) begin
        errors++;
        $display("FAIL reset_outputs t=%0t got=%h want=%h", $time, dut_vec, 20'h0);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (dut_vec !== e) begin
        errors++;
        $display("FAIL trace t=%0t got=%h want=%h", $time, dut_vec, e);
      end
    end
    if (fin || cyc > 20000) begin
      checks++;
      if (!fin || exp_q.size() != 0) begin
        errors++;
        $display("FAIL completion finished=%0d pending=%0d want finished=1 pending=0",
                 fin, exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    msg_valid  = 1'b0;
    num_blocks = 2'd0;
    last_sel   = 2'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_job(1, 0, 0, 0);
    run_job(2, 0, 0, 0);
    run_job(1, 2, 0, 0);
    bad_start(2'd0);
    bad_start(2'd3);

    // abort together with start in IDLE: nothing happens
    start      = 1'b1;
    abort      = 1'b1;
    num_blocks = 2'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    push(idle_vec(last_sel), 1'b0, 1'b0);
    push(idle_vec(last_sel), 1'b0, 1'b0);
    drive();

    run_job(2, 0, 2, 30);
    run_job(1, 0, 0, 0);

    // Asynchronous reset in the middle of ROUND, between clock edges
    start      = 1'b1;
    num_blocks = 2'd2;
    @(posedge clk);
    #1;
    start     = 1'b0;
    msg_valid = 1'b1;
    repeat (40) @(posedge clk);
    #2 rst_n = 1'b0;
    msg_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    last_sel = 2'd0;
    @(posedge clk);
    #1;
    run_job(1, 0, 0, 0);

    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, 2), 1, 0, 0);
      if ($urandom_range(0, 1) == 1) bad_start($urandom_range(0, 1) == 1 ? 2'd3 : 2'd0);
    end
    fin = 1'b1;
  end

endmodule
